uart_rx_stream: RTL and testbench
=================================

UART_RX_STREAM -- requirements
Module: uart_rx_stream

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, is the i_clk cycles per UART bit; legal values are >= 4.
REQ-002 Parameter FIFO_AW, default 4, is log2 of the receive FIFO depth; legal values are 1..8.
REQ-003 i_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_uart_rx  in  1  asynchronous serial line; idle is high.
REQ-006 o_data  out  8  received byte at the FIFO head; feeds the wbcon command stream i_rx_data.
REQ-007 o_valid  out  1  FIFO is non-empty.
REQ-008 i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
REQ-009 o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 o_overrun  out  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
REQ-011 o_parity_err  out  1  one-cycle pulse when the parity check fails; tied 0 unless UART_RX_PARITY_EN is defined.

Function
REQ-012 i_uart_rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value (2-cycle input latency).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY (only with the macro), STOP and WAIT_IDLE.
REQ-014 IDLE: on a synchronized high-to-low edge -> START, with the bit counter loaded to CLKS_PER_BIT/2 - 1 (integer division).
REQ-015 START: when the counter expires, line low -> DATA with the counter reloaded to CLKS_PER_BIT-1; line high -> IDLE (glitch rejected, no pulse raised).
REQ-016 DATA: the line is sampled at each counter expiry; 8 bits are collected LSB first into a shift register; after bit 7 -> PARITY (macro defined) or STOP.
REQ-017 STOP: line sampled high at expiry -> the byte is pushed and the FSM returns to IDLE; sampled low -> o_frame_err pulses, the byte is discarded, and the FSM goes to WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL remain until the synchronized line is high, then -> IDLE; a break condition therefore yields exactly one frame_err.
REQ-019 A pushed byte SHALL appear on o_valid/o_data on the cycle after the stop-bit sample when the FIFO is empty.
REQ-020 The FIFO SHALL be first-word-fall-through with depth 2^FIFO_AW, wrap-around pointers, and a FIFO_AW+1-bit occupancy count.
REQ-021 A push when full without a same-cycle pop SHALL be dropped and pulse o_overrun; FIFO contents stay unchanged.
REQ-022 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full or holds one entry; occupancy is then unchanged.
REQ-023 o_data and o_valid SHALL remain stable while o_valid && !i_ready.
REQ-024 Error pulses SHALL NOT suppress later frames, and only one error pulse fires per frame.

Reset
REQ-025 Reset SHALL force: FSM to IDLE, counters to 0, FIFO empty, o_valid=0, o_data=0, all error outputs 0, synchronizer flops to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; the first byte after reset requires a fresh falling edge.

Configuration
REQ-027 With UART_RX_PARITY_EN defined, one even-parity bit follows bit 7 and is sampled in PARITY; on mismatch o_parity_err pulses at the stop-bit sample time and the byte is discarded; a failing stop bit takes precedence and only o_frame_err pulses.
REQ-028 With UART_RX_PARITY_EN undefined, the frame is 8N1, the PARITY state and its logic are absent, and o_parity_err is constant 0.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state encoding and the data-bit count constant (8).
REQ-030 The FIFO SHALL be a separate sub-module, uart_rx_fifo, parameterized by data width and FIFO_AW.

Verification (CLKS_PER_BIT=16, FIFO_AW=2)
REQ-031 Send 0xA5 in 8N1 with i_ready=1 -> exactly one handshake with o_data=0xA5, and no error pulses.
REQ-032 Send a 5-cycle low glitch on an idle line -> no o_valid and no errors, and the FSM returns to IDLE.
REQ-033 Send 0x3C with the stop bit low, then 0x11 -> one o_frame_err pulse, 0x3C not delivered, 0x11 delivered.
REQ-034 Send 5 bytes 0x01..0x05 with i_ready=0 -> o_overrun pulses once; then raising i_ready delivers 0x01..0x04 in order.
REQ-035 Assert i_rst during bit 4 of a frame, then send 0x7E -> only 0x7E is delivered.
REQ-036 With UART_RX_PARITY_EN defined, send 0x03 with parity bit 1 -> one o_parity_err pulse and no byte delivered; send 0x03 with parity bit 0 -> 0x03 is delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART receive stream.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned DataBits = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity   = 3'd3,
`endif
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO, depth 2**Aw, with an overrun flag for a
// push that finds the FIFO full and is not relieved by a same-cycle pop.
module uart_rx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic             overrun_o
);

  localparam int unsigned Depth = 1 << Aw;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_ptr_q, rd_ptr_q;
  logic [Aw:0]      count_q;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == (Aw + 1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  // A pop frees the slot a full FIFO's write pointer aliases, so both may proceed.
  assign do_push = push_i && (!full || do_pop);

  assign overrun_o = push_i && full && !do_pop;
  assign valid_o   = !empty;
  assign rdata_o   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      if (do_push && !do_pop)      count_q <= count_q + (Aw + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (Aw + 1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through byte FIFO with valid/ready output.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitCntW = $clog2(DataBits);
  localparam logic [CntW-1:0]    FullLoad = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitCntW-1:0] LastBit  = BitCntW'(DataBits - 1);

  uart_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitCntW-1:0]  bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic                rx_meta_q, rx_sync_q, rx_prev_q;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, fifo_overrun;
  logic                push, expire;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_err_q, parity_err_d;
`endif

  assign expire = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rx_sync_q) begin
          state_d = StData;
          cnt_d   = FullLoad;
          bit_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rx_sync_q, shift_q[DataBits-1:1]};
          cnt_d   = FullLoad;
          bit_d   = bit_q + BitCntW'(1);
          if (bit_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          par_d   = rx_sync_q;
          cnt_d   = FullLoad;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rx_sync_q) begin
          // A bad stop bit outranks a parity mismatch.
          frame_err_d = 1'b1;
          state_d     = StWaitIdle;
        end else begin
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          if (par_q != ^shift_q) parity_err_d = 1'b1;
          else                   push         = 1'b1;
`else
          push = 1'b1;
`endif
        end
      end
      StWaitIdle: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_meta_q   <= i_uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      frame_err_q <= frame_err_d;
      overrun_q   <= fifo_overrun;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

  uart_rx_fifo #(
    .Width (DataBits),
    .Aw    (FIFO_AW)
  ) u_fifo (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .push_i    (push),
    .wdata_i   (shift_q),
    .pop_i     (o_valid && i_ready),
    .rdata_o   (o_data),
    .valid_o   (o_valid),
    .overrun_o (fifo_overrun)
  );

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: directed scenarios plus randomized
// frames scored against a queue model of the byte stream.
module tb_uart_rx_stream;

  localparam int CLKS  = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_frame_err, o_overrun, o_parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Observations, written only by the monitor.
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         n_frame = 0;
  int         n_over  = 0;
  int         n_par   = 0;

  uart_rx_stream #(
    .CLKS_PER_BIT (CLKS),
    .FIFO_AW      (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_uart_rx    (rx),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && ready) begin
        got_q.push_back(o_data);
        got_cyc_q.push_back(cyc);
      end
      if (o_frame_err)  n_frame++;
      if (o_overrun)    n_over++;
      if (o_parity_err) n_par++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int idle);
    rx = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      tick(CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    tick(CLKS);
`else
    if (par) rx = 1'b1;
`endif
    rx = stop;
    tick(CLKS);
    rx = 1'b1;
    tick(idle);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid);
    else n_pass++;
    n_checks++;
    if (o_data !== 8'h00) $display("FAIL reset_data got %h want 00", o_data);
    else n_pass++;
    n_checks++;
    if ({o_frame_err, o_overrun, o_parity_err} !== 3'b000)
      $display("FAIL reset_errs got %b want 000", {o_frame_err, o_overrun, o_parity_err});
    else n_pass++;
    rst = 1'b0;
    tick(2 * CLKS);
  endtask

  task automatic test_single;
    int b, f, o, t0;
    b = got_q.size(); f = n_frame; o = n_over;
    ready = 1'b1;
    t0 = cyc;
    send_frame(8'hA5, ^8'hA5, 1'b1, 2 * CLKS);
    n_checks++;
    if (got_q.size() - b != 1) $display("FAIL single_count got %0d want 1", got_q.size() - b);
    else n_pass++;
    n_checks++;
    if (got_q.size() > b && got_q[b] !== 8'hA5)
      $display("FAIL single_data got %h want a5", got_q[b]);
    else if (got_q.size() > b) n_pass++;
    else $display("FAIL single_data got none want a5");
    n_checks++;
    // Two sync flops, one edge-detect cycle, half a bit, then data+parity+stop bits.
    if (got_cyc_q.size() > b && got_cyc_q[b] - t0 != 3 + CLKS / 2 + (9 + PBITS) * CLKS)
      $display("FAIL single_latency got %0d want %0d", got_cyc_q[b] - t0,
               3 + CLKS / 2 + (9 + PBITS) * CLKS);
    else if (got_cyc_q.size() > b) n_pass++;
    else $display("FAIL single_latency got none");
    n_checks++;
    if (n_frame - f + n_over - o + n_par != 0)
      $display("FAIL single_errs got %0d want 0", n_frame - f + n_over - o + n_par);
    else n_pass++;
  endtask

  task automatic test_glitch;
    int b, f;
    b = got_q.size(); f = n_frame;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(3 * CLKS);
    n_checks++;
    if (got_q.size() != b || n_frame != f || n_par != 0)
      $display("FAIL glitch got bytes=%0d frame=%0d want 0 0", got_q.size() - b, n_frame - f);
    else n_pass++;
    send_frame(8'h5A, ^8'h5A, 1'b1, 2 * CLKS);
    n_checks++;
    if (got_q.size() != b + 1 || got_q[b] !== 8'h5A)
      $display("FAIL glitch_recover got count=%0d want 1 byte 5a", got_q.size() - b);
    else n_pass++;
  endtask

  task automatic test_frame_err;
    int b, f;
    b = got_q.size(); f = n_frame;
    send_frame(8'h3C, ^8'h3C, 1'b0, CLKS);
    send_frame(8'h11, ^8'h11, 1'b1, 2 * CLKS);
    n_checks++;
    if (n_frame - f != 1) $display("FAIL frame_err_pulses got %0d want 1", n_frame - f);
    else n_pass++;
    n_checks++;
    if (got_q.size() != b + 1 || got_q[b] !== 8'h11)
      $display("FAIL frame_err_data got count=%0d want 1 byte 11", got_q.size() - b);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int b, o;
    logic stable;
    logic [7:0] exp_q[$];
    b = got_q.size(); o = n_over;
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), ^8'(i), 1'b1, 4);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
    end
    tick(CLKS);
    n_checks++;
    if (n_over - o != 1) $display("FAIL overrun_pulses got %0d want 1", n_over - o);
    else n_pass++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (o_valid !== 1'b1 || o_data !== exp_q[0]) stable = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL overrun_hold got valid=%b data=%h want 1 %h", o_valid, o_data,
                          exp_q[0]);
    else n_pass++;
    ready = 1'b1;
    tick(10);
    n_checks++;
    if (got_q.size() - b != exp_q.size())
      $display("FAIL overrun_count got %0d want %0d", got_q.size() - b, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && b + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[b + i] !== exp_q[i])
        $display("FAIL overrun_order[%0d] got %h want %h", i, got_q[b + i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame;
    int b, f;
    b = got_q.size(); f = n_frame;
    rx = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      tick(CLKS);
    end
    rx = 1'b1;
    tick(CLKS / 2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3 * CLKS);
    send_frame(8'h7E, ^8'h7E, 1'b1, 2 * CLKS);
    n_checks++;
    if (got_q.size() != b + 1 || got_q[b] !== 8'h7E || n_frame != f)
      $display("FAIL reset_mid_frame got count=%0d frame=%0d want 1 byte 7e, 0 errs",
               got_q.size() - b, n_frame - f);
    else n_pass++;
  endtask

  // Random bytes, gaps and stop-bit faults against a queue model.
  task automatic test_random(input int n, input bit back_to_back);
    int b, f;
    int exp_frame;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic good;
    int idle;
    b = got_q.size(); f = n_frame; exp_frame = 0;
    ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      d    = 8'($urandom);
      good = back_to_back || ($urandom_range(5) != 0);
      idle = back_to_back ? 0 : (good ? $urandom_range(20) : 4 + $urandom_range(16));
      send_frame(d, ^d, good, idle);
      if (good) exp_q.push_back(d);
      else exp_frame++;
    end
    tick(2 * CLKS);
    n_checks++;
    if (n_frame - f != exp_frame)
      $display("FAIL random_frame_errs got %0d want %0d", n_frame - f, exp_frame);
    else n_pass++;
    n_checks++;
    if (got_q.size() - b != exp_q.size())
      $display("FAIL random_count got %0d want %0d", got_q.size() - b, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && b + i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[b + i] !== exp_q[i])
        $display("FAIL random_data[%0d] got %h want %h", i, got_q[b + i], exp_q[i]);
      else n_pass++;
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int b, p;
    b = got_q.size(); p = n_par;
    send_frame(8'h03, 1'b1, 1'b1, 2 * CLKS);
    n_checks++;
    if (n_par - p != 1 || got_q.size() != b)
      $display("FAIL parity_bad got perr=%0d bytes=%0d want 1 0", n_par - p, got_q.size() - b);
    else n_pass++;
    send_frame(8'h03, 1'b0, 1'b1, 2 * CLKS);
    n_checks++;
    if (n_par - p != 1 || got_q.size() != b + 1 || got_q[b] !== 8'h03)
      $display("FAIL parity_good got perr=%0d bytes=%0d want 1 1", n_par - p, got_q.size() - b);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid_frame();
    test_random(6, 1'b1);
    test_random(20, 1'b0);
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    n_checks++;
    if (n_par != 0 && PBITS == 0) $display("FAIL parity_tied got %0d pulses want 0", n_par);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
